// File: rtl/gamepad_event_arbiter_if.sv
// Event stream bundle between the gamepad event arbiter and its consumer.
// The arbiter drives valid/data at the FIFO head, and the consumer drives ready.
interface gamepad_event_arbiter_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [5:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/gamepad_event_arbiter.sv
// Turns two controllers' button levels into a queued stream of press/release events.
// Inputs are snapshotted once per frame. The 24 slots are then scanned, one per cycle, into a shared FIFO.
module gamepad_event_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [11:0]              btn0,
  input  logic [11:0]              btn1,
  input  logic [1:0]               present,
  input  logic                     frame_strobe,
  input  logic                     clr_flags,
  gamepad_event_arbiter_if.master  evt,
  output logic [CNT_W-1:0]         fifo_count,
  output logic                     fifo_overflow,
  output logic                     frame_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  state_t           state_next;
  logic             snap;
  logic             scan_last;
  logic [4:0]       slot;
  logic             first_player;
  logic [1:0][11:0] masked;
  logic [1:0][11:0] cur;
  logic [1:0][11:0] chg;
  logic [1:0][11:0] prev;
  logic             player;
  logic [3:0]       idx;
  logic             push_req;
  logic [5:0]       push_data;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [5:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign masked[0] = btn0 & {12{present[0]}};
  assign masked[1] = btn1 & {12{present[1]}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    snap       = 1'b0;
    scan_last  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_strobe) begin
          snap       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (slot == 5'd23) begin
          scan_last  = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // The change mask is frozen at snapshot time, so input motion during a scan cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur          <= '0;
      chg          <= '0;
      prev         <= '0;
      slot         <= '0;
      first_player <= 1'b0;
    end else if (snap) begin
      cur  <= masked;
      chg  <= masked ^ prev;
      prev <= masked;
      slot <= '0;
    end else if (state == SCAN) begin
      slot <= slot + 5'd1;
      if (scan_last) first_player <= ~first_player;
    end
  end

  assign player    = first_player ^ slot[0];
  assign idx       = slot[4:1];
  assign push_req  = (state == SCAN) && chg[player][idx];
  assign push_data = {player, cur[player][idx], idx};

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign pop     = evt.evt_valid && evt.evt_ready;
  assign full    = (fifo_count == FULL_COUNT);
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign evt.evt_valid = (fifo_count != '0);
  assign evt.evt_data  = evt.evt_valid ? mem[rd_ptr] : 6'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_overflow <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      fifo_overflow <= (push_req && full && !pop) | (fifo_overflow & ~clr_flags);
      frame_overrun <= ((state == SCAN) && frame_strobe) | (frame_overrun & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_gamepad_event_arbiter.sv
// Directed testbench for gamepad_event_arbiter. Each scenario task drives stimulus
// and checks against hand-computed event encodings {player, pressed, idx}.
module tb_gamepad_event_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] btn0 = '0;
  logic [11:0] btn1 = '0;
  logic [1:0]  present = '0;
  logic        frame_strobe = 1'b0;
  logic        clr_flags = 1'b0;
  logic [3:0]  fifo_count;
  logic        fifo_overflow;
  logic        frame_overrun;

  int checks = 0;
  int passed = 0;
  logic [5:0] got[$];

  gamepad_event_arbiter_if evt_if();

  gamepad_event_arbiter #(.FIFO_DEPTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn0          (btn0),
    .btn1          (btn1),
    .present       (present),
    .frame_strobe  (frame_strobe),
    .clr_flags     (clr_flags),
    .evt           (evt_if),
    .fifo_count    (fifo_count),
    .fifo_overflow (fifo_overflow),
    .frame_overrun (frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Logs each event that the upcoming edge will pop, then advances one cycle.
  task automatic collect(input int n);
    repeat (n) begin
      if (evt_if.evt_valid && evt_if.evt_ready) got.push_back(evt_if.evt_data);
      step(1);
    end
  endtask

  task automatic pulse_strobe();
    frame_strobe = 1'b1;
    collect(1);
    frame_strobe = 1'b0;
  endtask

  function automatic logic [5:0] evt_at(input int i);
    if (i < got.size()) return got[i];
    return 6'bxxxxxx;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    btn0 = '0;
    btn1 = '0;
    present = '0;
    frame_strobe = 1'b0;
    clr_flags = 1'b0;
    evt_if.evt_ready = 1'b0;
    got.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (evt_if.evt_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", evt_if.evt_valid);
    else passed++;
    checks++;
    if (evt_if.evt_data !== 6'h00) $display("[TB] FAIL reset_data: got %h expected 00", evt_if.evt_data);
    else passed++;
    checks++;
    if (fifo_count !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count);
    else passed++;
    checks++;
    if ({fifo_overflow, frame_overrun} !== 2'b00)
      $display("[TB] FAIL reset_flags: got %b expected 00", {fifo_overflow, frame_overrun});
    else passed++;
  endtask

  task automatic test_single_press();
    do_reset();
    btn0 = 12'h800;
    present = 2'b01;
    evt_if.evt_ready = 1'b1;
    pulse_strobe();
    collect(22);
    checks++;
    if (evt_if.evt_valid !== 1'b0) $display("[TB] FAIL single_early_valid: got %b expected 0", evt_if.evt_valid);
    else passed++;
    collect(1);
    checks++;
    if (evt_if.evt_valid !== 1'b1) $display("[TB] FAIL single_valid_t24: got %b expected 1", evt_if.evt_valid);
    else passed++;
    checks++;
    if (evt_if.evt_data !== 6'b011011) $display("[TB] FAIL single_data: got %b expected 011011", evt_if.evt_data);
    else passed++;
    checks++;
    if (fifo_count !== 4'd1) $display("[TB] FAIL single_count_one: got %0d expected 1", fifo_count);
    else passed++;
    collect(1);
    checks++;
    if (fifo_count !== 4'd0) $display("[TB] FAIL single_count_zero: got %0d expected 0", fifo_count);
    else passed++;
    collect(10);
    checks++;
    if (got.size() !== 1) $display("[TB] FAIL single_event_total: got %0d expected 1", got.size());
    else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    btn0 = 12'h001;
    btn1 = 12'h001;
    present = 2'b11;
    evt_if.evt_ready = 1'b1;
    pulse_strobe();
    collect(30);
    checks++;
    if (got.size() !== 2) $display("[TB] FAIL rr_f1_size: got %0d expected 2", got.size());
    else passed++;
    checks++;
    if (evt_at(0) !== 6'h10) $display("[TB] FAIL rr_f1_first: got %h expected 10", evt_at(0));
    else passed++;
    checks++;
    if (evt_at(1) !== 6'h30) $display("[TB] FAIL rr_f1_second: got %h expected 30", evt_at(1));
    else passed++;
    btn0 = '0;
    btn1 = '0;
    pulse_strobe();
    collect(30);
    checks++;
    if (got.size() !== 4) $display("[TB] FAIL rr_f2_size: got %0d expected 4", got.size());
    else passed++;
    checks++;
    if (evt_at(2) !== 6'h20) $display("[TB] FAIL rr_f2_first: got %h expected 20", evt_at(2));
    else passed++;
    checks++;
    if (evt_at(3) !== 6'h00) $display("[TB] FAIL rr_f2_second: got %h expected 00", evt_at(3));
    else passed++;
  endtask

  // Fills the FIFO, pops once while full during a push, then overflows.
  task automatic test_overflow();
    logic [5:0] exp;
    do_reset();
    btn0 = 12'hFFF;
    btn1 = 12'hFFF;
    present = 2'b11;
    pulse_strobe();
    collect(8);
    checks++;
    if (fifo_count !== 4'd8) $display("[TB] FAIL ovf_full_count: got %0d expected 8", fifo_count);
    else passed++;
    evt_if.evt_ready = 1'b1;
    collect(1);
    evt_if.evt_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd8) $display("[TB] FAIL ovf_pop_push_count: got %0d expected 8", fifo_count);
    else passed++;
    checks++;
    if (fifo_overflow !== 1'b0) $display("[TB] FAIL ovf_pop_push_flag: got %b expected 0", fifo_overflow);
    else passed++;
    got.delete();
    collect(16);
    checks++;
    if (fifo_count !== 4'd8) $display("[TB] FAIL ovf_sat_count: got %0d expected 8", fifo_count);
    else passed++;
    checks++;
    if (fifo_overflow !== 1'b1) $display("[TB] FAIL ovf_flag_set: got %b expected 1", fifo_overflow);
    else passed++;
    evt_if.evt_ready = 1'b1;
    collect(12);
    checks++;
    if (got.size() !== 8) $display("[TB] FAIL ovf_drain_size: got %0d expected 8", got.size());
    else passed++;
    for (int k = 1; k <= 8; k++) begin
      exp = {k[0], 1'b1, 4'(k >> 1)};
      checks++;
      if (evt_at(k - 1) !== exp) $display("[TB] FAIL ovf_drain_evt%0d: got %h expected %h", k, evt_at(k - 1), exp);
      else passed++;
    end
    checks++;
    if (fifo_count !== 4'd0) $display("[TB] FAIL ovf_drained_count: got %0d expected 0", fifo_count);
    else passed++;
    clr_flags = 1'b1;
    collect(1);
    clr_flags = 1'b0;
    checks++;
    if (fifo_overflow !== 1'b0) $display("[TB] FAIL ovf_flag_clear: got %b expected 0", fifo_overflow);
    else passed++;
  endtask

  task automatic test_overrun();
    do_reset();
    btn0 = 12'h001;
    present = 2'b01;
    evt_if.evt_ready = 1'b1;
    pulse_strobe();
    btn0 = '0;
    collect(9);
    frame_strobe = 1'b1;
    clr_flags = 1'b1;
    collect(1);
    frame_strobe = 1'b0;
    clr_flags = 1'b0;
    checks++;
    if (frame_overrun !== 1'b1) $display("[TB] FAIL overrun_set_wins: got %b expected 1", frame_overrun);
    else passed++;
    collect(14);
    checks++;
    if (got.size() !== 1) $display("[TB] FAIL overrun_one_scan: got %0d expected 1", got.size());
    else passed++;
    checks++;
    if (evt_at(0) !== 6'h10) $display("[TB] FAIL overrun_first_evt: got %h expected 10", evt_at(0));
    else passed++;
    pulse_strobe();
    collect(30);
    checks++;
    if (got.size() !== 2) $display("[TB] FAIL overrun_rescan_size: got %0d expected 2", got.size());
    else passed++;
    checks++;
    if (evt_at(1) !== 6'h00) $display("[TB] FAIL overrun_rescan_evt: got %h expected 00", evt_at(1));
    else passed++;
    clr_flags = 1'b1;
    collect(1);
    clr_flags = 1'b0;
    checks++;
    if (frame_overrun !== 1'b0) $display("[TB] FAIL overrun_clear: got %b expected 0", frame_overrun);
    else passed++;
  endtask

  task automatic test_presence_loss();
    do_reset();
    btn0 = 12'h010;
    present = 2'b01;
    evt_if.evt_ready = 1'b1;
    pulse_strobe();
    collect(30);
    checks++;
    if (evt_at(0) !== 6'h14) $display("[TB] FAIL presence_press: got %h expected 14", evt_at(0));
    else passed++;
    pulse_strobe();
    collect(30);
    checks++;
    if (got.size() !== 1) $display("[TB] FAIL presence_hold_quiet: got %0d expected 1", got.size());
    else passed++;
    present = 2'b00;
    pulse_strobe();
    collect(30);
    checks++;
    if (got.size() !== 2) $display("[TB] FAIL presence_release_size: got %0d expected 2", got.size());
    else passed++;
    checks++;
    if (evt_at(1) !== 6'h04) $display("[TB] FAIL presence_release: got %h expected 04", evt_at(1));
    else passed++;
    pulse_strobe();
    collect(30);
    checks++;
    if (got.size() !== 2) $display("[TB] FAIL presence_after_quiet: got %0d expected 2", got.size());
    else passed++;
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    btn0 = 12'h007;
    present = 2'b01;
    pulse_strobe();
    collect(6);
    checks++;
    if (fifo_count !== 4'd3) $display("[TB] FAIL midrst_queued: got %0d expected 3", fifo_count);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (evt_if.evt_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b expected 0", evt_if.evt_valid);
    else passed++;
    checks++;
    if (fifo_count !== 4'd0) $display("[TB] FAIL midrst_count: got %0d expected 0", fifo_count);
    else passed++;
    #2 rst_n = 1'b1;
    step(1);
    evt_if.evt_ready = 1'b1;
    got.delete();
    pulse_strobe();
    collect(30);
    checks++;
    if (got.size() !== 3) $display("[TB] FAIL midrst_regen_size: got %0d expected 3", got.size());
    else passed++;
    checks++;
    if ({evt_at(0), evt_at(1), evt_at(2)} !== {6'h10, 6'h11, 6'h12})
      $display("[TB] FAIL midrst_regen_evts: got %h %h %h expected 10 11 12", evt_at(0), evt_at(1), evt_at(2));
    else passed++;
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    test_reset();
    test_single_press();
    test_round_robin();
    test_overflow();
    test_overrun();
    test_presence_loss();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gamepad_event_arbiter.md
Name: gamepad_event_arbiter

Overview:
- Converts the decoded button vectors of two Gamepad Pmod controllers into a single queued stream of press and release events. Game logic can then consume input edges instead of polling levels.
- Sits between the dual gamepad decoder outputs and game/VGA logic.
- Snapshots inputs once per frame on a frame strobe (e.g. start of vblank).
- Schedules the 24 button slots onto one shared event FIFO, with round-robin player priority alternating every frame.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..32.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- btn0  in  12  controller 0 button levels, bit order {b,y,select,start,up,down,left,right,a,x,l,r} (bit 11 = b, bit 0 = r); 1 = pressed
- btn1  in  12  controller 1 button levels, same order
- present  in  2  controller present flags; present[p]=0 forces btnP to be treated as 0
- frame_strobe  in  1  one-cycle pulse requesting a snapshot and scan
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts the head event
- evt_data  out  6  {player, pressed, button_idx[3:0]}; button_idx is the bit position 0..11
- fifo_count  out  CNT_W  events currently queued
- fifo_overflow  out  1  sticky; an event was dropped because the FIFO was full
- frame_overrun  out  1  sticky; frame_strobe arrived while a scan was in progress
- clr_flags  in  1  clears both sticky flags

Behaviour:
- Reset (async assert, sync deassert usage): state=IDLE, cur/prev snapshots=0, first_player=0, FIFO empty, evt_valid=0, evt_data=0, fifo_count=0, both flags=0.
- States: IDLE, SCAN.
- IDLE transition: frame_strobe at cycle T does the following, then state=SCAN at T+1, slot counter k=0.
  - cur[p] <= btnP & {12{present[p]}}
  - chg[p] <= (btnP masked) ^ prev[p]
  - prev[p] <= btnP masked
- SCAN: one slot per cycle, k=0..23.
  - player = first_player ^ k[0]; button_idx = k[4:1].
  - If chg[player][button_idx]=1, push {player, cur[player][button_idx], button_idx}.
  - Slot k is examined at cycle T+1+k.
  - After k=23: state=IDLE and first_player toggles. IDLE is reached at T+25.
- frame_strobe during SCAN (cycles T+1..T+24) is ignored: no snapshot is taken, and frame_overrun is set. It is accepted again from T+25.
- Push latency: an event pushed at cycle C is visible at the head (evt_valid=1) at C+1 when the FIFO was empty.
- FIFO behaviour:
  - Registered head; evt_data is stable while evt_valid & !evt_ready.
  - Pop occurs when evt_valid & evt_ready.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle (full + pop + push: count unchanged).
  - Push when full without a pop: the event is dropped and fifo_overflow is set.
  - Empty + push + ready: no bypass; the event appears the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- fifo_count is exact every cycle (+1 push, -1 pop, 0 both).
- Sticky flags: clr_flags clears both flags. If clr_flags coincides with a set condition, set wins.
- Presence loss: present[p] falling means the next snapshot sees 0, producing release events for every held button of p. Reset-state prev=0 means buttons held at the first frame produce press events.
- Reset mid-scan: the scan is aborted, queued events are discarded, and all state returns to reset values immediately.
- Unchanged buttons produce no events. A press+release within one frame produces no event (level sampling only).

Test Plan:
- Reset, btn0=0x800 (b), present=2'b01, one frame_strobe, evt_ready=1 -> exactly one event evt_data=6'b0_1_1011, first valid at T+2+22=T+24 (slot k=22); fifo_count returns to 0.
- btn0=0x001 and btn1=0x001, present=2'b11, frame 1 -> events player0 then player1 (both idx0, pressed). Frame 2 with both released -> player1 release first, then player0 (first_player toggled).
- FIFO_DEPTH=8, evt_ready=0, btn0=btn1=0xFFF, present=2'b11 -> fifo_count saturates at 8, fifo_overflow=1, exactly 8 events drained afterward (slots k=0..7); clr_flags -> flag=0.
- frame_strobe at T and T+10 -> frame_overrun=1, only one scan occurs; strobe at T+25 starts a new scan.
- Hold btn0=0x010 across frames, then drop present[0] -> one release event {0,0,4'd4}, no further events on later frames.
- Assert rst_n=0 mid-scan with 3 events queued -> evt_valid=0, fifo_count=0 asynchronously; the next frame with the same inputs regenerates press events.
